// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream between the host and the chain loader.
// The host drives data/valid; the loader answers with ready.
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] din_data;
    logic              din_valid;
    logic              din_ready;

    modport master (
        output din_data,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din_data,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/ccff_chain_loader.sv
// Configuration flop chain loader: serializes bitstream words MSB-first
// onto ccff_head, gates the chain clock and optionally verifies a re-pass.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8,
    parameter int ERRCNT_W  = 16
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                start,
    input  logic                verify_en,
    ccff_chain_loader_if.slave  din,
    output logic                ccff_head,
    input  logic                ccff_tail,
    output logic                shift_en,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int WORDS     = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = CHAIN_LEN - (WORDS - 1) * WORD_W;
    localparam int BL_W      = $clog2(WORD_W + 1);
    localparam int BC_W      = $clog2(CHAIN_LEN + 1);
    localparam int WA_W      = $clog2(WORDS + 1);

    localparam logic [BL_W-1:0] BL_ONE  = BL_W'(1);
    localparam logic [BL_W-1:0] BL_FULL = BL_W'(WORD_W);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(LAST_BITS);

    localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(CHAIN_LEN - 1);
    localparam logic [BC_W-1:0] BC_END  = BC_W'(CHAIN_LEN);

    localparam logic [WA_W-1:0] WA_ONE   = WA_W'(1);
    localparam logic [WA_W-1:0] WA_FINAL = WA_W'(WORDS - 1);
    localparam logic [WA_W-1:0] WA_WORDS = WA_W'(WORDS);

    localparam logic [ERRCNT_W-1:0] ERR_ONE = ERRCNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] word_buf;
    logic [BL_W-1:0]   bits_left;
    logic [BC_W-1:0]   bit_cnt;
    logic [WA_W-1:0]   words_acc;
    logic              verify_q;
    logic              head_q;

    logic in_pass;
    logic accept;
    logic pass_end;
    logic cur_bit;
    logic mismatch;

    // Pass control: shifting, word acceptance and pass termination
    always_comb begin
        in_pass       = (state == S_LOAD) || (state == S_VERIFY);
        cur_bit       = word_buf[WORD_W-1];
        shift_en      = in_pass && (bits_left != '0)
                        && (bit_cnt < BC_END);
        din.din_ready = in_pass && (bits_left <= BL_ONE)
                        && (words_acc < WA_WORDS);
        accept        = din.din_valid && din.din_ready;
        pass_end      = shift_en && (bit_cnt == BC_LAST);
        mismatch      = (state == S_VERIFY) && shift_en
                        && (ccff_tail != cur_bit);
        ccff_head     = shift_en ? cur_bit : head_q;
        busy          = in_pass;
        done          = (state == S_DONE);
    end

    // Sequencer FSM with word buffer, counters and verify error tracking
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state     <= S_IDLE;
            word_buf  <= '0;
            bits_left <= '0;
            bit_cnt   <= '0;
            words_acc <= '0;
            verify_q  <= 1'b0;
            head_q    <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        verify_q  <= verify_en;
                        err       <= 1'b0;
                        err_count <= '0;
                        bits_left <= '0;
                        bit_cnt   <= '0;
                        words_acc <= '0;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD, S_VERIFY: begin
                    if (shift_en) begin
                        head_q    <= cur_bit;
                        word_buf  <= word_buf << 1;
                        bits_left <= bits_left - BL_ONE;
                        bit_cnt   <= bit_cnt + BC_ONE;
                    end
                    if (mismatch) begin
                        err <= 1'b1;
                        if (err_count != '1) begin
                            err_count <= err_count + ERR_ONE;
                        end
                    end
                    // A new word may land on the same edge as the last bit
                    if (accept) begin
                        word_buf  <= din.din_data;
                        bits_left <= (words_acc == WA_FINAL)
                                     ? BL_LAST : BL_FULL;
                        words_acc <= words_acc + WA_ONE;
                    end
                    if (pass_end) begin
                        bits_left <= '0;
                        bit_cnt   <= '0;
                        words_acc <= '0;
                        if ((state == S_LOAD) && verify_q) begin
                            state <= S_VERIFY;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Programming controller that sequences the configuration flip-flop chain of a CLB tile column.
- Accepts bitstream words over a valid/ready stream and serializes them MSB-first onto ccff_head.
- Drives a shift enable that gates the chain's prog_clk, so the chain advances only on shift cycles.
- Optional verify pass: the host re-supplies the identical bitstream; each bit emerging on ccff_tail is compared against the bit being shifted in.

Parameters:
- CHAIN_LEN, 1024, number of flops in the configuration chain (>=2).
- WORD_W, 8, bitstream word width (>=2).
- ERRCNT_W, 16, width of the saturating mismatch counter.

Ports:
- prog_clk  input  1  programming clock; all state on rising edge.
- pReset  input  1  synchronous, active-high reset.
- start  input  1  begin a programming sequence; sampled in IDLE or DONE only.
- verify_en  input  1  latched on accepted start; selects LOAD+VERIFY.
- din_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- din_valid  input  1  din_data valid.
- din_ready  output  1  word accepted when din_valid && din_ready.
- ccff_head  output  1  serial data into the chain.
- ccff_tail  input  1  serial data out of the chain.
- shift_en  output  1  chain clock enable; the chain shifts on each prog_clk edge where shift_en=1.
- busy  output  1  high in LOAD or VERIFY.
- done  output  1  high in DONE.
- err  output  1  sticky verify mismatch flag.
- err_count  output  ERRCNT_W  saturating mismatch count.

Behaviour:
- Clocking and reset: one clock (prog_clk). Reset is synchronous and active-high (pReset).
  - On reset, state goes to IDLE.
  - Reset values: din_ready=0, shift_en=0, ccff_head=0, busy=0, done=0, err=0, err_count=0.
  - Word buffer, bits_left and bit_cnt are cleared.
  - Reset mid-LOAD or mid-VERIFY aborts at once; shift_en is 0 from the next cycle. Chain contents are undefined thereafter.
- Word count: WORDS = ceil(CHAIN_LEN/WORD_W). In the final word of each pass only the top (CHAIN_LEN - (WORDS-1)*WORD_W) bits are shifted; the remaining low bits are discarded.
- State IDLE:
  - On start=1: latch verify_en, clear err and err_count, go to LOAD.
- State LOAD / VERIFY (a "pass"):
  - shift_en = (bits_left>0) && (bit_cnt<CHAIN_LEN). shift_en is combinational from registered state.
  - ccff_head = buf[WORD_W-1]. It is held at its last value when not shifting and is 0 after reset.
  - On a shift cycle: buf shifts left by 1, bits_left decrements, bit_cnt increments.
  - din_ready = (bits_left<=1) && (words_acc<WORDS). This allows a back-to-back accept in the same cycle as the last bit shifts, so there is no bubble.
  - On accept: buf<=din_data, bits_left<=WORD_W (or the residual count for the final word), words_acc increments.
  - No valid word means no shift; gaps are allowed, and chain timing depends only on shift_en.
  - The pass ends on the cycle bit_cnt reaches CHAIN_LEN. Counters (bit_cnt, words_acc, bits_left) clear at pass end.
  - LOAD end: go to VERIFY if verify_en was latched, else go to DONE.
  - VERIFY end: go to DONE.
- VERIFY compare:
  - On each shift cycle, compare ccff_tail (pre-edge value) with ccff_head.
  - On mismatch: err<=1; err_count increments and saturates at all-ones.
- State DONE:
  - done=1, busy=0, din_ready=0, shift_en=0.
  - err and err_count are held.
  - start=1 re-enters LOAD, behaving exactly as from IDLE.
- start and verify_en are ignored while busy.
- din_valid while din_ready=0 is not consumed.

Test Plan:
- Plain load, CHAIN_LEN=20, WORD_W=8, verify_en=0; words 0xA5, 0x3C, 0xF0 back-to-back:
  - exactly 20 shift_en cycles, contiguous;
  - ccff_head sequence 10100101 00111100 1111;
  - 3 accepts total;
  - done=1 the cycle after the 20th shift; err=0.
- Verify pass with a behavioural 20-flop chain model and the same 3 words twice → 40 shifts; err=0, err_count=0, done=1.
- Verify with the chain model forcing tail bit 5 inverted in the second pass → err=1, err_count=1; done still asserted after 40 shifts.
- Stalls: din_valid dropped for 3 cycles between words 1 and 2:
  - shift_en low exactly those 3 cycles;
  - total shift count still 20;
  - final chain contents identical to the no-stall case.
- Reset mid-LOAD after 9 shifts:
  - next cycle all outputs are at reset values;
  - a new start followed by 3 words completes with exactly 20 shifts.
- Saturation, ERRCNT_W=2, tail forced constantly inverted in VERIFY → err_count=3 (saturated); err=1; start in DONE clears both and restarts LOAD.
